// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the round-robin arbiter.
// The master side drives the requests. The slave side, which is the arbiter, drives the grant and the mux4 select.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;

    modport master (output req, done, input gnt, s, valid);
    modport slave  (input req, done, output gnt, s, valid);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a mux4. It keeps a registered one-hot grant and a bit-reversed 2-bit select.
// A hold counter limits how long one owner can keep the channel.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    mux4_rr_arbiter_if.slave bus
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("mux4_rr_arbiter: HOLD_MAX must lie in 1..255");
    end

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] owner, owner_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] gnt, gnt_nxt;
    logic [1:0] s, s_nxt;
    logic       valid, valid_nxt;

    logic [1:0] search_start;
    logic [2:0] pick;
    logic       rel;

    // Returns {found, index} for the first set request at or after start, searching modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [1:0] enc(input logic [1:0] k);
        return {k[0], k[1]};
    endfunction

    // After a release the search starts just past the owner, so the owner is considered last.
    assign search_start = (state == BUSY) ? owner + 2'd1 : ptr;
    assign pick         = rr_pick(bus.req, search_start);
    assign rel          = bus.done | ~bus.req[owner] | (cnt == HOLD_LIM);

    always_comb begin
        // NOTE: every output of this block gets a default first. A path that leaves one unassigned would infer a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        s_nxt     = s;
        valid_nxt = valid;

        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_nxt = BUSY;
                    owner_nxt = pick[1:0];
                    gnt_nxt   = 4'b0001 << pick[1:0];
                    s_nxt     = enc(pick[1:0]);
                    valid_nxt = 1'b1;
                    cnt_nxt   = 8'd1;
                end
            end
            BUSY: begin
                if (!rel) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    ptr_nxt = owner + 2'd1;
                    if (pick[2]) begin
                        owner_nxt = pick[1:0];
                        gnt_nxt   = 4'b0001 << pick[1:0];
                        s_nxt     = enc(pick[1:0]);
                        cnt_nxt   = 8'd1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        valid_nxt = 1'b0;
                        cnt_nxt   = 8'd0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            owner <= 2'd0;
            cnt   <= 8'd0;
            gnt   <= 4'b0000;
            s     <= 2'b00;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            s     <= s_nxt;
            valid <= valid_nxt;
        end
    end

    assign bus.gnt   = gnt;
    assign bus.s     = s;
    assign bus.valid = valid;

endmodule
